rtc_time_keeper: RTL

Parametrised real-time clock core that succeeds the fixed 12-hour counter. It keeps a 24-hour internal time base (hour/min/sec/sub-second) advanced by a per-tick enable. It presents the time in 12-hour or 24-hour format, selectable at run time. It also supports a validated time-load handshake and a one-shot daylight-saving adjustment state machine. It sits between the kHz tick source and the display/alarm logic.

---
 rtl/rtc_time_keeper.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rtc_time_keeper.sv
// 24-hour real-time clock core with 12/24-hour display decode, a validated time load
// and a one-shot daylight-saving jump.
module rtc_time_keeper #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int MS_W          = $clog2(TICKS_PER_SEC),
  parameter int DST_HOUR      = 2
) (
  input  logic              kh_clk,
  input  logic              reset_n,
  input  logic              tick_en,
  input  logic              mode_24,
  input  logic [1:0]        dst_mode,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [4:0]        set_hr,
  input  logic [5:0]        set_min,
  input  logic [5:0]        set_sec,
  output logic              set_err,
  output logic [16+MS_W:0]  disp_time,
  output logic              pm,
  output logic              dst_applied
);

  // state     | meaning
  // S_IDLE    | no DST adjustment requested
  // S_ARMED   | waiting for the DST_HOUR rollover
  // S_DONE    | jump taken, held until dst_mode returns to none
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} dst_state_t;

  localparam logic [MS_W-1:0] SUB_MAX   = MS_W'(TICKS_PER_SEC - 1);
  localparam logic [MS_W-1:0] SUB_ONE   = MS_W'(1);
  localparam logic [4:0]      HR_TRIG   = 5'(DST_HOUR - 1);
  localparam logic [4:0]      HR_SPRING = 5'(DST_HOUR + 1);
  localparam logic [4:0]      HR_FALL   = 5'(DST_HOUR - 1);

  dst_state_t      r_state;
  logic [4:0]      r_hr;
  logic [5:0]      r_min;
  logic [5:0]      r_sec;
  logic [MS_W-1:0] r_sub;
  logic            r_ready;
  logic            r_set_err;
  logic            r_dst_applied;
  logic            r_pm;

  logic            w_dst_on;
  logic            w_load;
  logic            w_set_ok;
  logic            w_load_ok;
  logic            w_trigger;
  logic            w_jump;
  logic [4:0]      w_hr_n;
  logic [5:0]      w_min_n;
  logic [5:0]      w_sec_n;
  logic [MS_W-1:0] w_sub_n;
  logic [4:0]      w_hr_disp;

  assign w_dst_on  = (dst_mode == 2'b01) || (dst_mode == 2'b10);
  assign w_load    = set_valid && r_ready;
  assign w_set_ok  = (set_hr <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);
  assign w_load_ok = w_load && w_set_ok;
  // The tick that would land exactly on DST_HOUR:00:00.000.
  assign w_trigger = tick_en && (r_sub == SUB_MAX) && (r_sec == 6'd59) &&
                     (r_min == 6'd59) && (r_hr == HR_TRIG);
  assign w_jump    = (r_state == S_ARMED) && w_dst_on && w_trigger && !w_load_ok;

  always_comb begin
    w_hr_n  = r_hr;
    w_min_n = r_min;
    w_sec_n = r_sec;
    w_sub_n = r_sub;
    if (w_load_ok) begin
      w_hr_n  = set_hr;
      w_min_n = set_min;
      w_sec_n = set_sec;
      w_sub_n = '0;
    end else if (tick_en) begin
      if (r_sub == SUB_MAX) begin
        w_sub_n = '0;
        if (r_sec == 6'd59) begin
          w_sec_n = 6'd0;
          if (r_min == 6'd59) begin
            w_min_n = 6'd0;
            w_hr_n  = (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
          end else begin
            w_min_n = r_min + 6'd1;
          end
        end else begin
          w_sec_n = r_sec + 6'd1;
        end
      end else begin
        w_sub_n = r_sub + SUB_ONE;
      end
      // Lower fields already roll to zero at the trigger, so only the hour is overridden.
      if (w_jump) w_hr_n = (dst_mode == 2'b01) ? HR_SPRING : HR_FALL;
    end
  end

  always_ff @(posedge kh_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_hr          <= 5'd0;
      r_min         <= 6'd0;
      r_sec         <= 6'd0;
      r_sub         <= '0;
      r_pm          <= 1'b0;
      r_ready       <= 1'b0;
      r_set_err     <= 1'b0;
      r_dst_applied <= 1'b0;
    end else begin
      r_hr          <= w_hr_n;
      r_min         <= w_min_n;
      r_sec         <= w_sec_n;
      r_sub         <= w_sub_n;
      r_pm          <= (w_hr_n >= 5'd12);
      r_ready       <= 1'b1;
      r_set_err     <= w_load && !w_set_ok;
      r_dst_applied <= w_jump;
      case (r_state)
        S_IDLE:  if (w_dst_on) r_state <= S_ARMED;
        S_ARMED: begin
          if (!w_dst_on)   r_state <= S_IDLE;
          else if (w_jump) r_state <= S_DONE;
        end
        S_DONE:  if (!w_dst_on) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_hr_disp = r_hr;
    if (!mode_24) begin
      if (r_hr == 5'd0)       w_hr_disp = 5'd12;
      else if (r_hr > 5'd12)  w_hr_disp = r_hr - 5'd12;
    end
  end

  assign disp_time   = {w_hr_disp, r_min, r_sec, r_sub};
  assign pm          = r_pm;
  assign set_ready   = r_ready;
  assign set_err     = r_set_err;
  assign dst_applied = r_dst_applied;

endmodule
